// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: the hex glyph set used by both the display
// path and the capture path, plus segment bit positions.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high a..g. The 6 keeps its top bar, the 9 its bottom bar, 7 is a,b,c only,
  // and b/d are lowercase.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex glyph table: an active-low segment pattern
// maps to a nibble plus legal/blank flags.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  logic [6:0] lit;

  assign lit   = ~seg_n;
  assign blank = (lit == SEG_BLANK);

  // NOTE: every output gets a default before the search loop, so no latch is inferred.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lit == SEG_GLYPH[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Reconstructs the hex word shown on a multiplexed active-low seven-segment bus.
// Optional macro SEG_CAPTURE_DP_EN adds the decimal-point input dp_n and output dp.
module seg_capture
  import seg_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     dig_en,
`ifdef SEG_CAPTURE_DP_EN
  input  logic                  dp_n,
  output logic [DIGITS-1:0]     dp,
`endif
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_ok,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

`ifdef SEG_CAPTURE_DP_EN
  localparam int SW = 8 + DIGITS;
  localparam logic [SW-1:0] SAMPLE_RST = {1'b1, 7'h7F, {DIGITS{1'b0}}};
  logic [SW-1:0] cur;
  logic [DIGITS-1:0] dp_d;
  assign cur = {dp_n, seg_n, dig_en};
`else
  localparam int SW = 7 + DIGITS;
  localparam logic [SW-1:0] SAMPLE_RST = {7'h7F, {DIGITS{1'b0}}};
  logic [SW-1:0] cur;
  assign cur = {seg_n, dig_en};
`endif

  logic [SW-1:0]         sample_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DIGITS-1:0]     seen_q, seen_d, ok_d;
  logic [4*DIGITS-1:0]   value_d;
  logic                  changed, capture, fv_d, err_d;
  logic [3:0]            nibble;
  logic                  legal, blank;

  seg_pattern_decode u_decode (
    .seg_n  (seg_n),
    .nibble (nibble),
    .legal  (legal),
    .blank  (blank)
  );

  // Saturating run length; the capture fires only on the step into SETTLE.
  assign changed = (cur != sample_q);
  assign cnt_d   = changed ? CW'(1) : ((cnt_q == SETTLE_C) ? cnt_q : cnt_q + 1'b1);
  assign capture = (cnt_d == SETTLE_C) && (changed || (cnt_q != SETTLE_C));

  always_comb begin
    value_d = value;
    ok_d    = digit_ok;
    seen_d  = seen_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
    dp_d    = dp;
`endif
    if (capture && (dig_en != '0)) begin
      if (!$onehot(dig_en)) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_en[i]) begin
            seen_d[i] = 1'b1;
            ok_d[i]   = legal;
            if (legal) value_d[4*i +: 4] = nibble;
            if (!legal && !blank) err_d = 1'b1;
`ifdef SEG_CAPTURE_DP_EN
            if (legal || blank) dp_d[i] = ~dp_n;
`endif
          end
        end
        // An illegal glyph that completes the frame still closes it, but only err
        // pulses so the two strobes never coincide.
        if (&seen_d) begin
          seen_d = '0;
          fv_d   = ~err_d;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_q    <= SAMPLE_RST;
      cnt_q       <= '0;
      value       <= '0;
      digit_ok    <= '0;
      seen_q      <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
      dp          <= '0;
`endif
    end else begin
      sample_q    <= cur;
      cnt_q       <= cnt_d;
      value       <= value_d;
      digit_ok    <= ok_d;
      seen_q      <= seen_d;
      frame_valid <= fv_d;
      err         <= err_d;
`ifdef SEG_CAPTURE_DP_EN
      dp          <= dp_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: a run-length based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_seg_capture;

  localparam int DIGITS = 3;
  localparam int SETTLE = 4;

  // Active-low hex glyphs, written independently of the design package.
  localparam logic [6:0] GLYPH_N [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [6:0]           seg_n;
  logic [DIGITS-1:0]    dig_en;
  logic [4*DIGITS-1:0]  value;
  logic [DIGITS-1:0]    digit_ok;
  logic                 frame_valid;
  logic                 err;

  int n_vec  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  seg_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_en      (dig_en),
    .value       (value),
    .digit_ok    (digit_ok),
    .frame_valid (frame_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: run length of identical samples, capture when it equals SETTLE.
  logic [4*DIGITS-1:0]   m_val;
  logic [DIGITS-1:0]     m_ok, m_seen;
  logic [7+DIGITS-1:0]   m_prev;
  int                    m_run;
  bit                    m_fv, m_err;

  function automatic void lookup(input logic [6:0] s, output bit legal, output bit blank,
                                 output logic [3:0] nib);
    legal = 1'b0;
    nib   = 4'h0;
    blank = (s == 7'h7F);
    for (int k = 0; k < 16; k++)
      if (s == GLYPH_N[k]) begin
        legal = 1'b1;
        nib   = 4'(k);
      end
  endfunction

  always @(posedge clk) begin : model
    logic [4*DIGITS-1:0] v;
    logic [DIGITS-1:0]   ok, sn;
    logic [3:0]          nib;
    bit                  legal, blank, e, f;
    int                  r, idx;
    if (!rst_n) begin
      m_val  <= '0;
      m_ok   <= '0;
      m_seen <= '0;
      m_prev <= {7'h7F, {DIGITS{1'b0}}};
      m_run  <= 0;
      m_fv   <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      v  = m_val;
      ok = m_ok;
      sn = m_seen;
      e  = 1'b0;
      f  = 1'b0;
      r  = ({seg_n, dig_en} == m_prev) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
      if (r == SETTLE && $countones(dig_en) > 1) begin
        e = 1'b1;
      end else if (r == SETTLE && $countones(dig_en) == 1) begin
        idx = 0;
        for (int k = 0; k < DIGITS; k++) if (dig_en[k]) idx = k;
        lookup(seg_n, legal, blank, nib);
        sn[idx] = 1'b1;
        ok[idx] = legal;
        if (legal) v[4*idx +: 4] = nib;
        else e = !blank;
        if (&sn) begin
          sn = '0;
          f  = !e;
        end
      end
      m_val  <= v;
      m_ok   <= ok;
      m_seen <= sn;
      m_prev <= {seg_n, dig_en};
      m_run  <= r;
      m_fv   <= f;
      m_err  <= e;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("value", 64'(value), 64'(m_val));
      check("digit_ok", 64'(digit_ok), 64'(m_ok));
      check("frame_valid", 64'(frame_valid), 64'(m_fv));
      check("err", 64'(err), 64'(m_err));
    end
  end

  task automatic drive(input logic [DIGITS-1:0] d, input logic [6:0] s);
    dig_en = d;
    seg_n  = s;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int errs;
    rst_n  = 1'b0;
    seg_n  = 7'h7F;
    dig_en = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);

    // Reset with random inputs, then 10 quiet cycles
    for (int k = 0; k < 3; k++) begin
      seg_n  = 7'($urandom);
      dig_en = DIGITS'($urandom);
      cycles(1);
    end
    check("rst_value", 64'(value), 64'h0);
    check("rst_ok", 64'(digit_ok), 64'h0);
    check("rst_fv", 64'(frame_valid), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    drive('0, 7'h7F);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      check("idle_pulses", 64'({frame_valid, err}), 64'h0);
    end

    // A53 frame, with the SETTLE-1 latency pinned on digit 0
    drive(3'b001, GLYPH_N[3]);
    cycles(3);
    check("latency_early", 64'(value), 64'h0);
    cycles(1);
    check("latency_capture", 64'(value), 64'h003);
    drive(3'b010, GLYPH_N[5]);
    cycles(4);
    check("no_frame_yet", 64'(frame_valid), 64'h0);
    drive(3'b100, GLYPH_N[10]);
    cycles(4);
    check("a53_value", 64'(value), 64'hA53);
    check("a53_ok", 64'(digit_ok), 64'h7);
    check("a53_fv", 64'(frame_valid), 64'h1);
    cycles(1);
    check("a53_fv_one_cycle", 64'(frame_valid), 64'h0);

    // Short hold: no capture
    drive(3'b001, GLYPH_N[8]);
    cycles(3);
    drive('0, 7'h7F);
    cycles(4);
    check("short_hold_value", 64'(value), 64'hA53);

    // Illegal pattern on digit 1
    drive(3'b010, ~7'b0000001);
    cycles(4);
    check("illegal_err", 64'(err), 64'h1);
    check("illegal_value", 64'(value), 64'hA53);
    check("illegal_ok", 64'(digit_ok), 64'h5);

    // Non-one-hot select held 20 cycles: one err pulse only
    drive(3'b011, GLYPH_N[7]);
    errs = 0;
    for (int k = 0; k < 20; k++) begin
      cycles(1);
      if (err) errs++;
    end
    check("multi_sel_err_count", 64'(errs), 64'h1);
    check("multi_sel_value", 64'(value), 64'hA53);

    // A 9 without bottom bar is not a legal glyph
    drive(3'b001, 7'h18);
    cycles(4);
    check("bad9_err", 64'(err), 64'h1);
    check("bad9_ok", 64'(digit_ok), 64'h4);

    // Blank: value kept, digit_ok cleared, no err
    drive(3'b001, 7'h7F);
    cycles(4);
    check("blank_err", 64'(err), 64'h0);
    check("blank_value", 64'(value), 64'hA53);

    // Partial frame discarded by reset
    drive(3'b001, GLYPH_N[1]);
    cycles(4);
    drive(3'b010, GLYPH_N[12]);
    cycles(4);
    check("partial_value", 64'(value), 64'hAC1);
    check("partial_fv", 64'(frame_valid), 64'h0);
    drive('0, 7'h7F);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    check("midreset_value", 64'(value), 64'h0);
    drive(3'b100, GLYPH_N[14]);
    cycles(4);
    check("after_reset_no_fv", 64'(frame_valid), 64'h0);
    drive(3'b001, GLYPH_N[15]);
    cycles(4);
    drive(3'b010, GLYPH_N[13]);
    cycles(4);
    check("edf_fv", 64'(frame_valid), 64'h1);
    check("edf_value", 64'(value), 64'hEDF);

    // The ambiguous glyphs in their team form
    drive(3'b001, GLYPH_N[6]);
    cycles(4);
    drive(3'b010, GLYPH_N[9]);
    cycles(4);
    drive(3'b100, GLYPH_N[11]);
    cycles(4);
    check("b96_value", 64'(value), 64'hB96);
    check("b96_fv", 64'(frame_valid), 64'h1);
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
